// File: rtl/cellrv32_package.sv
// Shared types and constants for the co-processor issue stage.
// Holds the issue FSM state encoding and the default co-processor timeout.
package cellrv32_package;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } cp_issue_state_t;

    localparam int cp_timeout_c = 64;

endpackage

// File: rtl/cellrv32_cpu_cp_issue.sv
// Co-processor issue/wait/capture sequencer: req->start 1 cycle, valid->done 2 cycles.
// No backpressure: busy_o stalls execute; requests while busy are dropped, trap_i aborts silently.
module cellrv32_cpu_cp_issue
    import cellrv32_package::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_CP     = 4,
    parameter int CP_TIMEOUT = cp_timeout_c
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic [$clog2(NUM_CP):0]  sel_i,
    input  logic                     trap_i,
    output logic [NUM_CP-1:0]        cp_start_o,
    input  logic [NUM_CP-1:0]        cp_valid_i,
    input  logic [NUM_CP*XLEN-1:0]   cp_res_i,
    output logic                     busy_o,
    output logic [XLEN-1:0]          res_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    localparam int SEL_W = $clog2(NUM_CP) + 1;
    localparam int CNT_W = $clog2(CP_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CP_TIMEOUT - 1);

    cp_issue_state_t   state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              done_q, done_d;
    logic              tout_q, tout_d;

    logic [NUM_CP-1:0] sel_oh;
    logic              sel_vld;
    logic [XLEN-1:0]   sel_res;

    // One-hot decode of the latched target and AND-OR result mux.
    always_comb begin
        sel_oh  = '0;
        sel_res = '0;
        for (int i = 0; i < NUM_CP; i++) begin
            sel_oh[i] = (sel_q == SEL_W'(i));
            sel_res   = sel_res | (cp_res_i[i*XLEN +: XLEN] & {XLEN{sel_q == SEL_W'(i)}});
        end
        sel_vld = |(cp_valid_i & sel_oh);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        done_d  = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (sel_i < SEL_W'(NUM_CP)) begin
                        sel_d   = sel_i;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end else begin
                        res_d  = '0;
                        done_d = 1'b1;
                        tout_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = trap_i ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                // Trap beats valid, valid beats timeout.
                if (trap_i) begin
                    state_d = S_IDLE;
                end else if (sel_vld) begin
                    state_d = S_CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    res_d   = '0;
                    done_d  = 1'b1;
                    tout_d  = 1'b1;
                end
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                state_d = S_IDLE;
                if (!trap_i) begin
                    res_d  = sel_res;
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            done_q  <= done_d;
            tout_q  <= tout_d;
        end
    end

    assign cp_start_o = (state_q == S_ISSUE) ? sel_oh : '0;
    assign busy_o     = (state_q != S_IDLE);
    assign res_o      = res_q;
    assign done_o     = done_q;
    assign timeout_o  = tout_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_issue.sv
// Randomized bench for the co-processor issue stage against a per-operation timing model.
module tb_cellrv32_cpu_cp_issue;

    localparam int XLEN       = 32;
    localparam int NUM_CP     = 4;
    localparam int CP_TIMEOUT = 64;
    localparam int SEL_W      = $clog2(NUM_CP) + 1;

    logic                   clk_i;
    logic                   rst_i;
    logic                   req_i;
    logic [SEL_W-1:0]       sel_i;
    logic                   trap_i;
    logic [NUM_CP-1:0]      cp_start_o;
    logic [NUM_CP-1:0]      cp_valid_i;
    logic [NUM_CP*XLEN-1:0] cp_res_i;
    logic                   busy_o;
    logic [XLEN-1:0]        res_o;
    logic                   done_o;
    logic                   timeout_o;

    cellrv32_cpu_cp_issue #(
        .XLEN       (XLEN),
        .NUM_CP     (NUM_CP),
        .CP_TIMEOUT (CP_TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .sel_i      (sel_i),
        .trap_i     (trap_i),
        .cp_start_o (cp_start_o),
        .cp_valid_i (cp_valid_i),
        .cp_res_i   (cp_res_i),
        .busy_o     (busy_o),
        .res_o      (res_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: last delivered result and a completion owed to the next cycle.
    logic [XLEN-1:0] res_m;
    logic            pend_done;
    logic            pend_tout;
    logic [XLEN-1:0] pend_res;
    logic [XLEN-1:0] cur_res [NUM_CP];
    logic            fix_en;
    logic [XLEN-1:0] fix_val;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [NUM_CP-1:0] onehot(input int s);
        logic [NUM_CP-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

    task automatic after_reset();
        res_m     = '0;
        pend_done = 1'b0;
        pend_tout = 1'b0;
        pend_res  = '0;
    endtask

    // Drive one cycle of inputs, then compare every output mid-cycle.
    task automatic step(input logic rst, input logic req, input logic [SEL_W-1:0] sel,
                        input logic trap, input logic [NUM_CP-1:0] vld,
                        input logic exp_busy, input logic [NUM_CP-1:0] exp_start);
        rst_i      = rst;
        req_i      = req;
        sel_i      = sel;
        trap_i     = trap;
        cp_valid_i = vld;
        for (int i = 0; i < NUM_CP; i++) begin
            cur_res[i] = fix_en ? fix_val : XLEN'($urandom);
            cp_res_i[i*XLEN +: XLEN] = cur_res[i];
        end
        @(negedge clk_i);
        if (pend_done) res_m = pend_res;
        check("busy",    64'(busy_o),     64'(exp_busy));
        check("start",   64'(cp_start_o), 64'(exp_start));
        check("done",    64'(done_o),     64'(pend_done));
        check("timeout", 64'(timeout_o),  64'(pend_tout));
        check("res",     64'(res_o),      64'(res_m));
        pend_done = 1'b0;
        pend_tout = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, SEL_W'($urandom), 1'($urandom), NUM_CP'($urandom), 1'b0, '0);
        end
    endtask

    // One operation. d: valid delay after start (0 = never), tk: trap cycle
    // relative to req (-1 none), rk: reset cycle relative to req (-1 none).
    task automatic run_op(input logic [SEL_W-1:0] sel, input int d, input int tk,
                          input int rk, input bit noise);
        int                s, kv, kd, end_k;
        bit                tmo, trapped;
        logic [XLEN-1:0]   cap;
        logic [NUM_CP-1:0] v;
        logic              rq;
        logic [SEL_W-1:0]  sv;
        s   = int'(sel);
        cap = '0;
        if (s >= NUM_CP) begin
            v = noise ? NUM_CP'($urandom) : '0;
            step(rk == 0, 1'b1, sel, tk == 0, v, 1'b0, '0);
            if (rk == 0) begin
                after_reset();
            end else begin
                pend_done = 1'b1;
                pend_tout = 1'b1;
                pend_res  = '0;
            end
            return;
        end
        tmo     = !(d >= 1 && d <= CP_TIMEOUT);
        kv      = tmo ? -1 : d + 1;
        kd      = tmo ? CP_TIMEOUT + 2 : kv + 2;
        trapped = (tk >= 1) && (tk <= kd - 1);
        end_k   = trapped ? tk + 1 : kd;
        for (int k = 0; k < end_k; k++) begin
            rq   = (k == 0) ? 1'b1 : (noise && ($urandom_range(0, 7) == 0));
            sv   = (k == 0) ? sel : SEL_W'($urandom);
            v    = noise ? NUM_CP'($urandom) : '0;
            v[s] = (k == kv) ||
                   (noise && (k == 1 || (!tmo && k == kv + 1)) && ($urandom_range(0, 1) == 1));
            step(k == rk, rq, sv, k == tk, v, k >= 1, (k == 1) ? onehot(s) : '0);
            if (k == rk) begin
                after_reset();
                return;
            end
            if (!tmo && k == kv + 1) cap = cur_res[s];
        end
        if (!trapped) begin
            pend_done = 1'b1;
            pend_tout = tmo;
            pend_res  = tmo ? '0 : cap;
        end
    endtask

    initial begin
        int sel_r, d_r, tk_r, rk_r;
        rst_i      = 1'b1;
        req_i      = 1'b0;
        sel_i      = '0;
        trap_i     = 1'b0;
        cp_valid_i = '0;
        cp_res_i   = '0;
        fix_en     = 1'b0;
        fix_val    = '0;
        after_reset();
        repeat (2) @(posedge clk_i);
        #1;
        idle(2);

        // Fast co-processor, result 6.
        fix_en = 1'b1; fix_val = 32'h0000_0006;
        run_op(SEL_W'(1), 1, -1, -1, 1'b0);
        idle(1);
        // Slow co-processor, 32 cycles.
        fix_val = 32'hFFFF_FFFE;
        run_op(SEL_W'(0), 32, -1, -1, 1'b0);
        idle(1);
        // Never valid -> timeout.
        fix_en = 1'b0;
        run_op(SEL_W'(2), 0, -1, -1, 1'b1);
        idle(2);
        // Illegal target.
        run_op(SEL_W'(5), 0, -1, -1, 1'b0);
        idle(1);
        // Trap at WAIT cycle 10 keeps the previous result, then normal issue.
        fix_en = 1'b1; fix_val = 32'h0000_1234;
        run_op(SEL_W'(3), 5, -1, -1, 1'b0);
        idle(1);
        run_op(SEL_W'(2), 20, 11, -1, 1'b1);
        idle(2);
        fix_val = 32'h0000_ABCD;
        run_op(SEL_W'(2), 3, -1, -1, 1'b0);
        idle(1);
        // Valid on the last WAIT cycle beats the timeout.
        fix_en = 1'b0;
        run_op(SEL_W'(1), CP_TIMEOUT, -1, -1, 1'b1);
        idle(1);
        // Back-to-back: next request in the done cycle, then an illegal one too.
        run_op(SEL_W'(0), 2, -1, -1, 1'b1);
        run_op(SEL_W'(3), 4, -1, -1, 1'b1);
        run_op(SEL_W'(7), 0, -1, -1, 1'b1);
        run_op(SEL_W'(1), 1, -1, -1, 1'b1);
        idle(1);
        // Foreign valids, reset at WAIT cycle 5, late valids afterwards.
        run_op(SEL_W'(1), 10, -1, 6, 1'b1);
        idle(8);

        for (int n = 0; n < 200; n++) begin
            sel_r = $urandom_range(0, NUM_CP + 1);
            case ($urandom_range(0, 9))
                0, 1:    d_r = 0;
                2:       d_r = CP_TIMEOUT;
                default: d_r = $urandom_range(1, 40);
            endcase
            tk_r = ($urandom_range(0, 9) < 3) ? $urandom_range(0, 45) : -1;
            rk_r = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 30) : -1;
            run_op(SEL_W'(sel_r), d_r, tk_r, rk_r, 1'b1);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
